mem_port_arbiter: RTL and testbench

Shares one single-port synchronous memory between the CPU's instruction-fetch port and data-access port in the minimal SOPC. The minimal SOPC then needs a single unified instruction/data RAM instead of a separate instruction ROM. The block sits between the openmips core and the memory model. It grants one access at a time and returns read data with a fixed one-cycle memory latency. It raises a stall request to the core's pipeline control while any requester is waiting.

---
 rtl/mem_port_arbiter_pkg.sv | 28 ++
 rtl/mem_port_arbiter_if.sv | 58 +++++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Desc     : Shared constants and helpers for the fetch/data memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    localparam logic [1:0] c_ARB_IDLE    = 2'd0;
    localparam logic [1:0] c_ARB_WAIT_IF = 2'd1;
    localparam logic [1:0] c_ARB_WAIT_DM = 2'd2;

    localparam logic c_CHIP_ENABLE  = 1'b1;
    localparam logic c_CHIP_DISABLE = 1'b0;
    localparam logic c_WRITE_ENABLE = 1'b1;

    localparam int c_STARVE_W = 4;

    // Saturating increment used by the fetch-starvation counter.
    function automatic logic [c_STARVE_W-1:0] f_sat_inc(
        input logic [c_STARVE_W-1:0] value,
        input logic [c_STARVE_W-1:0] limit
    );
        return (value < limit) ? value + c_STARVE_W'(1) : limit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Desc     : Fetch port, data port and memory command bus of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int c_SEL_W = DATA_W / 8;

    logic                if_req_i;
    logic [ADDR_W-1:0]   if_addr_i;
    logic [DATA_W-1:0]   if_data_o;
    logic                if_ack_o;

    logic                dm_req_i;
    logic                dm_we_i;
    logic [c_SEL_W-1:0]  dm_sel_i;
    logic [ADDR_W-1:0]   dm_addr_i;
    logic [DATA_W-1:0]   dm_wdata_i;
    logic [DATA_W-1:0]   dm_rdata_o;
    logic                dm_ack_o;

    logic                mem_ce_o;
    logic                mem_we_o;
    logic [c_SEL_W-1:0]  mem_sel_o;
    logic [ADDR_W-1:0]   mem_addr_o;
    logic [DATA_W-1:0]   mem_wdata_o;
    logic [DATA_W-1:0]   mem_rdata_i;

    logic                stallreq_o;

    // Arbiter side.
    modport slave (
        input  if_req_i, if_addr_i,
        input  dm_req_i, dm_we_i, dm_sel_i, dm_addr_i, dm_wdata_i,
        input  mem_rdata_i,
        output if_data_o, if_ack_o,
        output dm_rdata_o, dm_ack_o,
        output mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o,
        output stallreq_o
    );

    // Core plus memory side.
    modport master (
        output if_req_i, if_addr_i,
        output dm_req_i, dm_we_i, dm_sel_i, dm_addr_i, dm_wdata_i,
        output mem_rdata_i,
        input  if_data_o, if_ack_o,
        input  dm_rdata_o, dm_ack_o,
        input  mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o,
        input  stallreq_o
    );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Desc     : Shares one single-port synchronous RAM between instruction fetch
//            and data access; one access per two cycles, data port preferred.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input wire                clk,
    input wire                rst,
    mem_port_arbiter_if.slave bus
);

    localparam int                    c_SEL_W       = DATA_W / 8;
    localparam logic [c_SEL_W-1:0]    c_MEM_SEL_ALL = '1;
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX  = c_STARVE_W'(STARVE_MAX);

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [c_STARVE_W-1:0] r_starve_cnt;
    logic                  r_we;

    logic                  w_idle;
    logic                  w_fetch_due;
    logic                  w_grant_dm;
    logic                  w_grant_if;

    logic                  w_if_ack;
    logic [DATA_W-1:0]     w_if_data;
    logic                  w_dm_ack;
    logic [DATA_W-1:0]     w_dm_rdata;
    logic                  w_mem_ce;
    logic                  w_mem_we;
    logic [c_SEL_W-1:0]    w_mem_sel;
    logic [ADDR_W-1:0]     w_mem_addr;
    logic [DATA_W-1:0]     w_mem_wdata;
    logic                  w_stallreq;

    // Data normally wins (older instruction); a fetch starved too long wins instead.
    assign w_idle      = (r_state == c_ARB_IDLE);
    assign w_fetch_due = bus.if_req_i & (r_starve_cnt == c_STARVE_MAX);
    assign w_grant_dm  = w_idle & bus.dm_req_i & ~w_fetch_due;
    assign w_grant_if  = w_idle & bus.if_req_i & ~w_grant_dm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ARB_IDLE: begin
                if (w_grant_dm) begin
                    w_state_next = c_ARB_WAIT_DM;
                end else if (w_grant_if) begin
                    w_state_next = c_ARB_WAIT_IF;
                end
            end
            c_ARB_WAIT_IF: w_state_next = c_ARB_IDLE;
            c_ARB_WAIT_DM: w_state_next = c_ARB_IDLE;
            default:       w_state_next = c_ARB_IDLE;
        endcase
    end

    always_comb begin
        w_if_ack    = 1'b0;
        w_if_data   = '0;
        w_dm_ack    = 1'b0;
        w_dm_rdata  = '0;
        w_mem_ce    = c_CHIP_DISABLE;
        w_mem_we    = 1'b0;
        w_mem_sel   = '0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (!rst) begin
            case (r_state)
                c_ARB_IDLE: begin
                    if (w_grant_dm) begin
                        w_mem_ce    = c_CHIP_ENABLE;
                        w_mem_we    = bus.dm_we_i;
                        w_mem_sel   = bus.dm_sel_i;
                        w_mem_addr  = bus.dm_addr_i;
                        w_mem_wdata = bus.dm_wdata_i;
                    end else if (w_grant_if) begin
                        w_mem_ce    = c_CHIP_ENABLE;
                        w_mem_sel   = c_MEM_SEL_ALL;
                        w_mem_addr  = bus.if_addr_i;
                    end
                end
                c_ARB_WAIT_IF: begin
                    w_if_ack  = 1'b1;
                    w_if_data = bus.mem_rdata_i;
                end
                c_ARB_WAIT_DM: begin
                    w_dm_ack   = 1'b1;
                    w_dm_rdata = (r_we == c_WRITE_ENABLE) ? '0 : bus.mem_rdata_i;
                end
                default: ;
            endcase
        end
    end

    assign w_stallreq = ~rst & ((bus.if_req_i & ~w_if_ack) | (bus.dm_req_i & ~w_dm_ack));

    // A low fetch request means nobody is starving, so the count restarts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (!bus.if_req_i || w_grant_if) begin
            r_starve_cnt <= '0;
        end else if (w_grant_dm) begin
            r_starve_cnt <= f_sat_inc(r_starve_cnt, c_STARVE_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we <= 1'b0;
        end else if (w_grant_dm) begin
            r_we <= bus.dm_we_i;
        end
    end

    assign bus.if_ack_o    = w_if_ack;
    assign bus.if_data_o   = w_if_data;
    assign bus.dm_ack_o    = w_dm_ack;
    assign bus.dm_rdata_o  = w_dm_rdata;
    assign bus.mem_ce_o    = w_mem_ce;
    assign bus.mem_we_o    = w_mem_we;
    assign bus.mem_sel_o   = w_mem_sel;
    assign bus.mem_addr_o  = w_mem_addr;
    assign bus.mem_wdata_o = w_mem_wdata;
    assign bus.stallreq_o  = w_stallreq;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Desc     : Vector table, corner sequences and random traffic for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int c_SM = 4;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;

    int n_tests  = 0;
    int n_fail   = 0;
    int viol_cnt = 0;

    logic [31:0] mem [1024];
    logic [31:0] sh  [1024];

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(c_SM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Unified single-port RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[64] <= 32'h3401_0020;
        end else if (bus.mem_ce_o) begin
            if (bus.mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_sel_o[b]) mem[bus.mem_addr_o[11:2]][b*8 +: 8] <= bus.mem_wdata_o[b*8 +: 8];
            end else begin
                bus.mem_rdata_i <= mem[bus.mem_addr_o[11:2]];
            end
        end
    end

    // Requester dropping req before its ack is counted as a protocol violation.
    logic m_rst_q = 1'b1, m_if_q = 1'b0, m_ifack_q = 1'b0, m_dm_q = 1'b0, m_dmack_q = 1'b0;
    always @(negedge clk) begin
        if (!rst && !m_rst_q) begin
            if ((m_if_q && !m_ifack_q && !bus.if_req_i) || (m_dm_q && !m_dmack_q && !bus.dm_req_i))
                viol_cnt <= viol_cnt + 1;
        end
        m_rst_q   <= rst;
        m_if_q    <= bus.if_req_i;
        m_ifack_q <= bus.if_ack_o;
        m_dm_q    <= bus.dm_req_i;
        m_dmack_q <= bus.dm_ack_o;
    end

    typedef struct {
        logic        rst;
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [3:0]  dm_sel;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic        e_if_ack;
        logic [31:0] e_if_data;
        logic        e_dm_ack;
        logic [31:0] e_dm_rdata;
        logic        e_ce;
        logic        e_we;
        logic [3:0]  e_sel;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_stall;
    } vec_t;

    vec_t vt [21];

    function automatic vec_t mk(
        input logic r, input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
        input logic [3:0] ds, input logic [31:0] da, input logic [31:0] dd,
        input logic eia, input logic [31:0] eid, input logic eda, input logic [31:0] edd,
        input logic ec, input logic ew, input logic [3:0] es, input logic [31:0] ea,
        input logic [31:0] ewd, input logic est
    );
        vec_t v;
        v.rst = r; v.if_req = ir; v.if_addr = ia; v.dm_req = dr; v.dm_we = dw;
        v.dm_sel = ds; v.dm_addr = da; v.dm_wdata = dd;
        v.e_if_ack = eia; v.e_if_data = eid; v.e_dm_ack = eda; v.e_dm_rdata = edd;
        v.e_ce = ec; v.e_we = ew; v.e_sel = es; v.e_addr = ea; v.e_wdata = ewd; v.e_stall = est;
        return v;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                          input logic [3:0] ds, input logic [31:0] da, input logic [31:0] dd);
        bus.if_req_i   = ir;
        bus.if_addr_i  = ia;
        bus.dm_req_i   = dr;
        bus.dm_we_i    = dw;
        bus.dm_sel_i   = ds;
        bus.dm_addr_i  = da;
        bus.dm_wdata_i = dd;
    endtask

    // Random-phase model state
    int          m_busy;
    int          m_starve;
    logic        m_we;
    logic [31:0] m_data;
    logic        if_pend, dm_pend, seen_if_ack, seen_dm_ack;
    logic        take_dm;
    logic        e_if_ack, e_dm_ack, e_ce, e_we, e_stall;
    logic [31:0] e_if_data, e_dm_rdata, e_addr, e_wdata;
    logic [3:0]  e_sel;
    int          ng;
    logic        g [6];
    logic [5:0]  g_exp;

    initial begin
        rst      = 1'b1;
        mem_init = 1'b1;
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step();
        mem_init = 1'b0;

        //            rst ifr ifaddr      dmr  we   sel    dmaddr      wdata          | ifack ifdata       dmack dmrdata      ce   we   sel    addr        wdata          stall
        vt[0]  = mk(1'b1,1'b1,32'h100,1'b1,1'b1,4'hF,32'h200,32'h1111_1111, 1'b0,32'h0,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0,1'b0);
        vt[1]  = mk(1'b0,1'b0,32'h0,  1'b0,1'b0,4'h0,32'h0,  32'h0,         1'b0,32'h0,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0,1'b0);
        vt[2]  = mk(1'b0,1'b1,32'h100,1'b0,1'b0,4'h0,32'h0,  32'h0,         1'b0,32'h0,1'b0,32'h0, 1'b1,1'b0,4'hF,32'h100,32'h0,1'b1);
        vt[3]  = mk(1'b0,1'b1,32'h100,1'b0,1'b0,4'h0,32'h0,  32'h0,         1'b1,32'h3401_0020,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0,1'b0);
        vt[4]  = mk(1'b0,1'b0,32'h0,  1'b1,1'b1,4'hF,32'h200,32'hDEAD_BEEF, 1'b0,32'h0,1'b0,32'h0, 1'b1,1'b1,4'hF,32'h200,32'hDEAD_BEEF,1'b1);
        vt[5]  = mk(1'b0,1'b0,32'h0,  1'b1,1'b1,4'hF,32'h200,32'hDEAD_BEEF, 1'b0,32'h0,1'b1,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0,1'b0);
        vt[6]  = mk(1'b0,1'b0,32'h0,  1'b1,1'b0,4'hF,32'h200,32'h0,         1'b0,32'h0,1'b0,32'h0, 1'b1,1'b0,4'hF,32'h200,32'h0,1'b1);
        vt[7]  = mk(1'b0,1'b0,32'h0,  1'b1,1'b0,4'hF,32'h200,32'h0,         1'b0,32'h0,1'b1,32'hDEAD_BEEF, 1'b0,1'b0,4'h0,32'h0,32'h0,1'b0);
        vt[8]  = mk(1'b0,1'b1,32'h100,1'b1,1'b0,4'hF,32'h200,32'h0,         1'b0,32'h0,1'b0,32'h0, 1'b1,1'b0,4'hF,32'h200,32'h0,1'b1);
        vt[9]  = mk(1'b0,1'b1,32'h100,1'b1,1'b0,4'hF,32'h200,32'h0,         1'b0,32'h0,1'b1,32'hDEAD_BEEF, 1'b0,1'b0,4'h0,32'h0,32'h0,1'b1);
        vt[10] = mk(1'b0,1'b1,32'h100,1'b0,1'b0,4'h0,32'h0,  32'h0,         1'b0,32'h0,1'b0,32'h0, 1'b1,1'b0,4'hF,32'h100,32'h0,1'b1);
        vt[11] = mk(1'b0,1'b1,32'h100,1'b0,1'b0,4'h0,32'h0,  32'h0,         1'b1,32'h3401_0020,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0,1'b0);
        vt[12] = mk(1'b0,1'b0,32'h0,  1'b1,1'b1,4'h2,32'h300,32'h0000_AB00, 1'b0,32'h0,1'b0,32'h0, 1'b1,1'b1,4'h2,32'h300,32'h0000_AB00,1'b1);
        vt[13] = mk(1'b0,1'b0,32'h0,  1'b1,1'b1,4'h2,32'h300,32'h0000_AB00, 1'b0,32'h0,1'b1,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0,1'b0);
        vt[14] = mk(1'b0,1'b1,32'h300,1'b0,1'b0,4'h0,32'h0,  32'h0,         1'b0,32'h0,1'b0,32'h0, 1'b1,1'b0,4'hF,32'h300,32'h0,1'b1);
        vt[15] = mk(1'b0,1'b1,32'h300,1'b0,1'b0,4'h0,32'h0,  32'h0,         1'b1,32'h0000_AB00,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0,1'b0);
        vt[16] = mk(1'b0,1'b0,32'h0,  1'b1,1'b0,4'hF,32'h200,32'h0,         1'b0,32'h0,1'b0,32'h0, 1'b1,1'b0,4'hF,32'h200,32'h0,1'b1);
        vt[17] = mk(1'b1,1'b0,32'h0,  1'b1,1'b0,4'hF,32'h200,32'h0,         1'b0,32'h0,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0,1'b0);
        vt[18] = mk(1'b0,1'b0,32'h0,  1'b1,1'b0,4'hF,32'h200,32'h0,         1'b0,32'h0,1'b0,32'h0, 1'b1,1'b0,4'hF,32'h200,32'h0,1'b1);
        vt[19] = mk(1'b0,1'b0,32'h0,  1'b1,1'b0,4'hF,32'h200,32'h0,         1'b0,32'h0,1'b1,32'hDEAD_BEEF, 1'b0,1'b0,4'h0,32'h0,32'h0,1'b0);
        vt[20] = mk(1'b0,1'b0,32'h0,  1'b0,1'b0,4'h0,32'h0,  32'h0,         1'b0,32'h0,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0,1'b0);

        for (int i = 0; i < 21; i++) begin
            rst = vt[i].rst;
            set_in(vt[i].if_req, vt[i].if_addr, vt[i].dm_req, vt[i].dm_we, vt[i].dm_sel, vt[i].dm_addr, vt[i].dm_wdata);
            @(negedge clk);
            chk1 ($sformatf("v%0d if_ack", i),    bus.if_ack_o,    vt[i].e_if_ack);
            chk32($sformatf("v%0d if_data", i),   bus.if_data_o,   vt[i].e_if_data);
            chk1 ($sformatf("v%0d dm_ack", i),    bus.dm_ack_o,    vt[i].e_dm_ack);
            chk32($sformatf("v%0d dm_rdata", i),  bus.dm_rdata_o,  vt[i].e_dm_rdata);
            chk1 ($sformatf("v%0d mem_ce", i),    bus.mem_ce_o,    vt[i].e_ce);
            chk1 ($sformatf("v%0d mem_we", i),    bus.mem_we_o,    vt[i].e_we);
            chk32($sformatf("v%0d mem_sel", i),   32'(bus.mem_sel_o), 32'(vt[i].e_sel));
            chk32($sformatf("v%0d mem_addr", i),  bus.mem_addr_o,  vt[i].e_addr);
            chk32($sformatf("v%0d mem_wdata", i), bus.mem_wdata_o, vt[i].e_wdata);
            chk1 ($sformatf("v%0d stallreq", i),  bus.stallreq_o,  vt[i].e_stall);
            step();
        end

        // Starvation: both held; expect D D D D F D grant order.
        set_in(1'b1, 32'h100, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
        ng = 0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            @(negedge clk);
            if (bus.mem_ce_o) begin
                g[ng] = (bus.mem_addr_o == 32'h100);
                ng++;
            end
            step();
        end
        chk32("starve grant count", 32'(ng), 32'd6);
        g_exp = 6'b010000;
        for (int k = 0; k < 6; k++) chk1($sformatf("starve grant%0d is_fetch", k), g[k], g_exp[k]);
        @(negedge clk);
        chk1("starve last dm_ack", bus.dm_ack_o, 1'b1);
        step();
        bus.dm_req_i = 1'b0;
        @(negedge clk);
        chk1 ("starve tail fetch ce", bus.mem_ce_o, 1'b1);
        chk32("starve tail fetch addr", bus.mem_addr_o, 32'h100);
        step();
        @(negedge clk);
        chk1 ("starve tail if_ack", bus.if_ack_o, 1'b1);
        chk32("starve tail if_data", bus.if_data_o, 32'h3401_0020);
        step();
        bus.if_req_i = 1'b0;

        // Protocol violation: data read dropped before its ack.
        chk32("viol count before", 32'(viol_cnt), 32'd0);
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
        @(negedge clk);
        chk1("viol grant ce", bus.mem_ce_o, 1'b1);
        step();
        bus.dm_req_i = 1'b0;
        @(negedge clk);
        chk1 ("viol ack still issued", bus.dm_ack_o, 1'b1);
        chk32("viol ack rdata", bus.dm_rdata_o, 32'hDEAD_BEEF);
        step();
        chk32("viol flagged", 32'(viol_cnt), 32'd1);

        // Random traffic against a transaction-level model.
        rst = 1'b1;
        step();
        @(negedge clk);
        chk1("rand reset stall", bus.stallreq_o, 1'b0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 1024; i++) sh[i] = mem[i];
        m_busy = 0; m_starve = 0; m_we = 1'b0; m_data = 32'h0;
        if_pend = 1'b0; dm_pend = 1'b0; seen_if_ack = 1'b0; seen_dm_ack = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (if_pend && seen_if_ack) if_pend = 1'b0;
            if (dm_pend && seen_dm_ack) dm_pend = 1'b0;
            if (!if_pend && $urandom_range(0, 2) != 0) begin
                if_pend = 1'b1;
                bus.if_addr_i = 32'($urandom_range(0, 1023)) << 2;
            end
            if (!dm_pend && $urandom_range(0, 2) != 0) begin
                dm_pend = 1'b1;
                bus.dm_we_i    = 1'($urandom_range(0, 1));
                bus.dm_sel_i   = 4'($urandom_range(1, 15));
                bus.dm_addr_i  = 32'($urandom_range(0, 1023)) << 2;
                bus.dm_wdata_i = $urandom;
            end
            bus.if_req_i = if_pend;
            bus.dm_req_i = dm_pend;
            @(negedge clk);

            e_if_ack = 1'b0; e_if_data = 32'h0; e_dm_ack = 1'b0; e_dm_rdata = 32'h0;
            e_ce = 1'b0; e_we = 1'b0; e_sel = 4'h0; e_addr = 32'h0; e_wdata = 32'h0;
            if (m_busy == 1) begin
                e_if_ack = 1'b1; e_if_data = m_data; m_busy = 0;
            end else if (m_busy == 2) begin
                e_dm_ack = 1'b1; e_dm_rdata = m_we ? 32'h0 : m_data; m_busy = 0;
            end else begin
                take_dm = dm_pend && !(if_pend && m_starve == c_SM);
                if (take_dm) begin
                    e_ce = 1'b1; e_we = bus.dm_we_i; e_sel = bus.dm_sel_i;
                    e_addr = bus.dm_addr_i; e_wdata = bus.dm_wdata_i;
                    m_busy = 2; m_we = bus.dm_we_i; m_data = sh[bus.dm_addr_i[11:2]];
                    if (bus.dm_we_i)
                        for (int b = 0; b < 4; b++)
                            if (bus.dm_sel_i[b]) sh[bus.dm_addr_i[11:2]][b*8 +: 8] = bus.dm_wdata_i[b*8 +: 8];
                    if (if_pend) m_starve = (m_starve < c_SM) ? m_starve + 1 : c_SM;
                end else if (if_pend) begin
                    e_ce = 1'b1; e_sel = 4'hF; e_addr = bus.if_addr_i;
                    m_busy = 1; m_data = sh[bus.if_addr_i[11:2]]; m_starve = 0;
                end
            end
            if (!if_pend) m_starve = 0;
            e_stall = (if_pend && !e_if_ack) || (dm_pend && !e_dm_ack);

            chk1("rand if_ack", bus.if_ack_o, e_if_ack);
            chk1("rand dm_ack", bus.dm_ack_o, e_dm_ack);
            chk1("rand mem_ce", bus.mem_ce_o, e_ce);
            chk1("rand stallreq", bus.stallreq_o, e_stall);
            if (e_if_ack) chk32("rand if_data", bus.if_data_o, e_if_data);
            if (e_dm_ack) chk32("rand dm_rdata", bus.dm_rdata_o, e_dm_rdata);
            if (e_ce) begin
                chk32("rand mem_addr", bus.mem_addr_o, e_addr);
                chk1 ("rand mem_we", bus.mem_we_o, e_we);
                chk32("rand mem_sel", 32'(bus.mem_sel_o), 32'(e_sel));
                if (e_we) chk32("rand mem_wdata", bus.mem_wdata_o, e_wdata);
            end
            seen_if_ack = bus.if_ack_o;
            seen_dm_ack = bus.dm_ack_o;
            step();
        end
        chk32("viol count after random", 32'(viol_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
